bdd_result_collector: RTL and testbench

//  Downstream stage of the BDD classifier top. Tracks one sample traversal at a time and

---
 rtl/bdd_result_collector.sv | 134 +++++++++++++
 tb/tb_bdd_result_collector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bdd_result_collector.sv
// Watches the classifier output for a leaf class, timestamps the traversal and queues
// {timeout, cycles, class} results in a small FIFO. Optional per-class histogram: BDD_COLLECTOR_HIST_EN.
module bdd_result_collector #(
    parameter int CLASS_W     = 8,
    parameter int CYC_W       = 16,
    parameter int MAX_CYCLES  = 1024,
    parameter int SETTLE      = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int NUM_CLASSES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           sample_ready,
    input  logic [CLASS_W-1:0]             class_in,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [CLASS_W-1:0]             res_class,
    output logic [CYC_W-1:0]               res_cycles,
    output logic                           res_timeout,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    input  logic [$clog2(NUM_CLASSES)-1:0] hist_sel,
    output logic [CYC_W-1:0]               hist_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE - 1);
    localparam logic [CYC_W-1:0] MAX_LAST    = CYC_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, WAIT_LEAF, PUSH} state_t;

    typedef struct packed {
        logic               timeout;
        logic [CYC_W-1:0]   cycles;
        logic [CLASS_W-1:0] cls;
    } entry_t;

    state_t           state;
    logic [CYC_W-1:0] counter;
    entry_t           cap;

    entry_t           mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             full, pop, push;
    entry_t           head;

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = (count != '0) && res_ready;
    // A pop in the same cycle frees the slot, so a full FIFO does not stall the push.
    assign push = (state == PUSH) && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            cap     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        counter <= '0;
                        state   <= SETTLE_WAIT;
                    end
                end
                SETTLE_WAIT: begin
                    counter <= counter + 1'b1;
                    if (counter == SETTLE_LAST) state <= WAIT_LEAF;
                end
                WAIT_LEAF: begin
                    counter <= counter + 1'b1;
                    // Leaf detection takes priority over the timeout in the same cycle.
                    if (class_in != '0) begin
                        cap   <= '{timeout: 1'b0, cycles: counter, cls: class_in};
                        state <= PUSH;
                    end else if (counter == MAX_LAST) begin
                        cap   <= '{timeout: 1'b1, cycles: counter, cls: '0};
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    if (push) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Head fields are forced to zero while empty so reset and drained states read clean.
    assign head         = mem[rd_ptr];
    assign res_valid    = (count != '0);
    assign res_class    = res_valid ? head.cls     : '0;
    assign res_cycles   = res_valid ? head.cycles  : '0;
    assign res_timeout  = res_valid ? head.timeout : 1'b0;
    assign fifo_count   = count;
    assign sample_ready = (state == IDLE);

`ifdef BDD_COLLECTOR_HIST_EN
    logic [NUM_CLASSES-1:0][CYC_W-1:0] bins;

    always_ff @(posedge clk) begin
        if (rst) begin
            bins <= '0;
        end else if (push && !cap.timeout) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (cap.cls == CLASS_W'(i) && bins[i] != '1) bins[i] <= bins[i] + 1'b1;
            end
        end
    end

    assign hist_count = bins[hist_sel];
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_bdd_result_collector.sv
// Bench for bdd_result_collector: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference of expected result entries.
module tb_bdd_result_collector;
    localparam int MAXC   = 1024;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst, start, res_ready;
    logic [7:0]  class_in;
    logic        sample_ready, res_valid, res_timeout;
    logic [7:0]  res_class;
    logic [15:0] res_cycles;
    logic [3:0]  fifo_count;
    logic [3:0]  hist_sel;
    logic [15:0] hist_count;

    bdd_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .sample_ready(sample_ready),
        .class_in(class_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_cycles(res_cycles), .res_timeout(res_timeout),
        .fifo_count(fifo_count), .hist_sel(hist_sel), .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cls;
        logic [15:0] cyc;
        logic        to;
    } ent_t;

    typedef struct {
        logic [7:0]  cls;
        int          at;
        logic [7:0]  ecls;
        logic [15:0] ecyc;
        logic        eto;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    bit   sb_en = 0;
    bit   rand_rdy = 0;
    ent_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference: a nonzero class held from counter 'at' is seen at the first
    // cycle past the settle window; class 0 forever means a timeout at MAXC-1.
    function automatic ent_t model(input logic [7:0] cls, input int at);
        ent_t e;
        if (cls == 0 || (at > SETTLE ? at : SETTLE) > MAXC - 1) begin
            e.cls = 0; e.cyc = 16'(MAXC - 1); e.to = 1;
        end else begin
            e.cls = cls; e.cyc = 16'(at > SETTLE ? at : SETTLE); e.to = 0;
        end
        return e;
    endfunction

    task automatic tick();
        ent_t e;
        if (sb_en && res_valid && res_ready) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_class", res_class, e.cls);
                chk("sb_cycles", res_cycles, e.cyc);
                chk("sb_timeout", res_timeout, e.to);
            end
        end
        @(posedge clk);
        #1;
        if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
    endtask

    // Launch one sample, drive class from counter 'at' onward, wait for return to IDLE.
    task automatic run_sample(input logic [7:0] cls, input int at, input int lim,
                              input bit hold_start, output bit done);
        int k;
        int w;
        w = 0;
        while (!sample_ready && w < 5000) begin tick(); w++; end
        start = 1;
        tick();
        start = hold_start;
        k = 0;
        do begin
            class_in = (k >= at) ? cls : 8'h00;
            if (k >= 2) start = 0;
            tick();
            k++;
        end while (!sample_ready && k < lim);
        start    = 0;
        class_in = 0;
        done     = sample_ready;
    endtask

    task automatic pop_check(input ent_t e, input string nm);
        chk({nm, "_valid"}, res_valid, 1);
        chk({nm, "_class"}, res_class, e.cls);
        chk({nm, "_cycles"}, res_cycles, e.cyc);
        chk({nm, "_timeout"}, res_timeout, e.to);
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    initial begin
        vec_t tv[6];
        ent_t e;
        bit   done;
        int   w;

        tv[0] = '{cls: 8'h07, at: 0,  ecls: 8'h07, ecyc: 16'd4,    eto: 1'b0};
        tv[1] = '{cls: 8'h09, at: 2,  ecls: 8'h09, ecyc: 16'd4,    eto: 1'b0};
        tv[2] = '{cls: 8'hff, at: 4,  ecls: 8'hff, ecyc: 16'd4,    eto: 1'b0};
        tv[3] = '{cls: 8'h01, at: 5,  ecls: 8'h01, ecyc: 16'd5,    eto: 1'b0};
        tv[4] = '{cls: 8'h80, at: 37, ecls: 8'h80, ecyc: 16'd37,   eto: 1'b0};
        tv[5] = '{cls: 8'h00, at: 0,  ecls: 8'h00, ecyc: 16'd1023, eto: 1'b1};

        rst = 1; start = 0; class_in = 0; res_ready = 0; hist_sel = 0;
        repeat (3) tick();
        chk("rst_sample_ready", sample_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_class", res_class, 0);
        chk("rst_res_cycles", res_cycles, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_hist", hist_count, 0);
        rst = 0;
        tick();

        // Leaf at counter 12: one PUSH cycle, then visible at the head.
        start = 1; tick(); start = 0;
        repeat (12) tick();
        class_in = 8'h05; tick(); class_in = 0;
        chk("lat_push_valid", res_valid, 0);
        chk("lat_push_ready", sample_ready, 0);
        tick();
        chk("lat_ready", sample_ready, 1);
        chk("lat_count", fifo_count, 1);
        pop_check('{cls: 8'h05, cyc: 16'd12, to: 1'b0}, "lat");

        for (int i = 0; i < 6; i++) begin
            run_sample(tv[i].cls, tv[i].at, 1200, 0, done);
            chk($sformatf("vec%0d_done", i), done, 1);
            pop_check('{cls: tv[i].ecls, cyc: tv[i].ecyc, to: tv[i].eto}, $sformatf("vec%0d", i));
        end

        // start held while busy must not launch a second traversal
        run_sample(8'h06, 10, 1200, 1, done);
        repeat (3) tick();
        chk("busy_start_count", fifo_count, 1);
        pop_check('{cls: 8'h06, cyc: 16'd10, to: 1'b0}, "busy_start");
        chk("busy_start_empty", fifo_count, 0);

        // Fill, stall in PUSH, then push and pop in the same cycle
        for (int i = 1; i <= 8; i++) run_sample(8'(i), 4, 100, 0, done);
        chk("full_count", fifo_count, 8);
        run_sample(8'h09, 4, 20, 0, done);
        chk("stall_ready", sample_ready, 0);
        chk("stall_count", fifo_count, 8);
        pop_check('{cls: 8'h01, cyc: 16'd4, to: 1'b0}, "full_pop1");
        chk("pushpop_count", fifo_count, 8);
        chk("pushpop_ready", sample_ready, 1);
        for (int i = 2; i <= 9; i++)
            pop_check('{cls: 8'(i), cyc: 16'd4, to: 1'b0}, $sformatf("drain%0d", i));
        chk("drained", fifo_count, 0);

        // Reset mid-traversal with entries queued
        for (int i = 0; i < 3; i++) run_sample(8'h11, 6, 100, 0, done);
        chk("pre_rst_count", fifo_count, 3);
        start = 1; tick(); start = 0;
        repeat (10) tick();
        rst = 1; tick(); rst = 0;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ready", sample_ready, 1);
        chk("mid_rst_class", res_class, 0);
        tick();
        run_sample(8'h22, 8, 100, 0, done);
        pop_check('{cls: 8'h22, cyc: 16'd8, to: 1'b0}, "post_rst");

`ifdef BDD_COLLECTOR_HIST_EN
        run_sample(8'h03, 4, 100, 0, done);
        run_sample(8'h03, 9, 100, 0, done);
        run_sample(8'd20, 4, 100, 0, done);
        run_sample(8'h00, 0, 1200, 0, done);
        for (int b = 0; b < 16; b++) begin
            hist_sel = 4'(b);
            #1;
            chk($sformatf("hist_bin%0d", b), hist_count, (b == 3) ? 2 : 0);
        end
        res_ready = 1; repeat (4) tick(); res_ready = 0;
`else
        chk("hist_off", hist_count, 0);
`endif

        // Randomized run with a random consumer
        sb_en = 1; rand_rdy = 1;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] c;
            int a;
            c = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            a = $urandom_range(0, 60);
            q.push_back(model(c, a));
            run_sample(c, a, 4000, 0, done);
            chk("rnd_done", done, 1);
        end
        rand_rdy = 0; res_ready = 1;
        w = 0;
        while (q.size() != 0 && w < 100) begin tick(); w++; end
        chk("rnd_queue_empty", q.size(), 0);
        chk("rnd_fifo_empty", fifo_count, 0);
        sb_en = 0; res_ready = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
